sw_txbuf_chan_sched: RTL
========================

Name: sw_txbuf_chan_sched

Overview:
- Packet-level round-robin scheduler for a multi-channel SW TX buffer.
- Software signals each committed packet per channel; the block keeps a per-channel pending-packet count and grants the shared buffer read/output path to one channel at a time.
- Scheduling is non-preemptive: a grant is held until that packet's EOP word is transferred.
- Sits between the software-write side (packet commit pulses) and the buffer read FSM that drives the FrameLink output.

Parameters:
CHANNELS, 4, number of TX channels (2..16)
CNT_WIDTH, 8, width of each pending-packet counter; max count 2^CNT_WIDTH-1

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-high reset
PKT_NEW  in  CHANNELS  one-cycle pulse per bit: one packet committed to channel i
CHAN_EN  in  CHANNELS  channel enable mask; only affects arbitration
TX_EOP  in  1  current output word is last word of packet
TX_SRC_RDY  in  1  buffer read side has a valid word
TX_DST_RDY  in  1  output sink accepts the word
GRANT  out  CHANNELS  one-hot selected channel; all zero when idle
GRANT_VLD  out  1  a channel is granted
PENDING  out  CHANNELS*CNT_WIDTH  registered counters, channel i at bits [i*CNT_WIDTH +: CNT_WIDTH]
OVERFLOW  out  CHANNELS  sticky: PKT_NEW dropped on saturated counter
OVF_CLR  in  1  synchronous clear of all OVERFLOW bits

Behaviour:
- Reset (async, immediate): GRANT=0, GRANT_VLD=0, all PENDING=0, OVERFLOW=0, FSM=IDLE, RR pointer=CHANNELS-1 so channel 0 has first priority.
- Definitions:
  - eligible(i) = CHAN_EN[i] & (PENDING_i != 0), using registered values.
  - eop_xfer = GRANT_VLD & TX_EOP & TX_SRC_RDY & TX_DST_RDY.
- Counter update, per channel, every cycle:
  - inc = PKT_NEW[i]; dec = eop_xfer & GRANT[i].
  - inc only: +1 if below max; at max the count holds and OVERFLOW[i] sets.
  - dec only: -1.
  - inc and dec together: count unchanged, no overflow even at max.
  - dec at zero cannot occur (a grant implies count >= 1).
- OVERFLOW:
  - set and OVF_CLR in the same cycle: set wins.
  - OVF_CLR otherwise clears all bits next cycle.
- FSM states IDLE, SEND:
  - IDLE: GRANT=0, GRANT_VLD=0.
    - If any channel is eligible, select the first eligible channel searching from pointer+1 upward modulo CHANNELS.
    - Register the selection into GRANT, set GRANT_VLD, go to SEND.
    - Latency: an eligible condition visible in cycle t gives GRANT_VLD=1 in cycle t+1.
    - A PKT_NEW in cycle t first appears in PENDING at t+1 and can produce a grant at t+2 at the earliest.
  - SEND: GRANT is held stable.
    - Non-EOP transfers and stalls (SRC_RDY or DST_RDY low) do not change state.
    - On eop_xfer: decrement the granted counter, set pointer=granted index, clear GRANT/GRANT_VLD, go to IDLE.
    - There is therefore exactly one idle cycle between consecutive packets.
- CHAN_EN deasserted for the granted channel during SEND: the packet completes, with no abort; the channel is skipped in later arbitration while disabled.
- PKT_NEW is accepted regardless of CHAN_EN or state.
- TX_* inputs are ignored while GRANT_VLD=0.
- RESET asserted mid-packet: grant drops immediately and counters are lost. The buffer read FSM shares RESET and must also abort.

Test Plan:
- Reset: assert RESET asynchronously between clock edges -> GRANT=0, GRANT_VLD=0, PENDING=0, OVERFLOW=0 immediately, without waiting for a clock edge.
- Single channel: 3 PKT_NEW pulses on ch2, CHAN_EN=1111, each packet 4 words with EOP on word 4 -> PENDING2 goes 1,2,3; GRANT=0100 three times; PENDING2 goes 2,1,0 at each EOP; one idle cycle between grants; GRANT_VLD=0 at end.
- Round robin: 2 packets each on ch0, ch1, ch3 loaded before enabling, then CHAN_EN=1111 -> grant order 0,1,3,0,1,3; ch2 never granted.
- Back-pressure: TX_DST_RDY low for 5 cycles on the EOP word -> GRANT held, PENDING unchanged until the cycle DST_RDY returns high.
- Saturation, CNT_WIDTH=2, CHAN_EN=0000: 4 PKT_NEW pulses on ch1 -> PENDING1=3, OVERFLOW=0010. Then enable, and in the EOP cycle of ch1's packet pulse PKT_NEW[1] -> PENDING1 stays 3, no new overflow. OVF_CLR -> OVERFLOW=0000.
- Disable mid-packet: ch0 granted, drop CHAN_EN[0] on word 2 -> grant held until EOP; next grant goes to ch1 (pending 1) even though PENDING0 > 0. Assert RESET mid-packet of ch1 -> all outputs 0, next grant after release starts from ch0.

Source files
------------

// File: rtl/sw_txbuf_chan_sched.sv
// Round-robin, non-preemptive packet scheduler for a multi-channel TX buffer.
// Counts committed packets per channel and grants the shared read path one whole packet at a time.
module sw_txbuf_chan_sched #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [CHANNELS-1:0]           PKT_NEW,
  input  logic [CHANNELS-1:0]           CHAN_EN,
  input  logic                          TX_EOP,
  input  logic                          TX_SRC_RDY,
  input  logic                          TX_DST_RDY,
  output logic [CHANNELS-1:0]           GRANT,
  output logic                          GRANT_VLD,
  output logic [CHANNELS*CNT_WIDTH-1:0] PENDING,
  output logic [CHANNELS-1:0]           OVERFLOW,
  input  logic                          OVF_CLR
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     gidx;
  logic [CNT_WIDTH-1:0] cnt [CHANNELS];

  logic [CHANNELS-1:0]  eligible;
  logic [CHANNELS-1:0]  inc;
  logic [CHANNELS-1:0]  dec;
  logic [CHANNELS-1:0]  ovf_set;
  logic                 eop_xfer;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     cand;
  logic [SUM_W-1:0]     sum;

  assign eop_xfer = GRANT_VLD & TX_EOP & TX_SRC_RDY & TX_DST_RDY;
  assign inc      = PKT_NEW;
  assign dec      = GRANT & {CHANNELS{eop_xfer}};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pend
    assign PENDING[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
  end

  // Eligibility and saturation detection from registered counters.
  always_comb begin
    eligible = '0;
    ovf_set  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      eligible[i] = CHAN_EN[i] && (cnt[i] != '0);
      ovf_set[i]  = inc[i] && !dec[i] && (cnt[i] == CNT_MAX);
    end
  end

  // First eligible channel after the pointer, wrapping modulo CHANNELS.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(CHANNELS)) begin
        sum = sum - SUM_W'(CHANNELS);
      end
      cand = sum[IDX_W-1:0];
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Pending-packet counters; simultaneous commit and EOP cancel out.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (inc[i] && !dec[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end else if (dec[i] && !inc[i]) begin
          cnt[i] <= cnt[i] - CNT_WIDTH'(1);
        end
      end
    end
  end

  // Sticky overflow flags; a new overflow beats a clear in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OVERFLOW <= '0;
    end else begin
      OVERFLOW <= ovf_set | (OVF_CLR ? '0 : OVERFLOW);
    end
  end

  // Grant FSM: hold the grant until the packet's EOP word is transferred.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      GRANT     <= '0;
      GRANT_VLD <= 1'b0;
      ptr       <= IDX_W'(CHANNELS - 1);
      gidx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            GRANT     <= CHANNELS'(1) << sel_idx;
            GRANT_VLD <= 1'b1;
            gidx      <= sel_idx;
            state     <= SEND;
          end
        end
        SEND: begin
          if (eop_xfer) begin
            ptr       <= gidx;
            GRANT     <= '0;
            GRANT_VLD <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          GRANT     <= '0;
          GRANT_VLD <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
